// File: rtl/sparse_pkg.sv
// Shared types and default sizing for the sparse activation encoder.
package sparse_pkg;
    localparam int ACT_BW = 4;
    localparam int DEPTH  = 4;
    localparam int NZ     = 2;
    localparam int IDX_BW = $clog2(DEPTH);

    typedef logic [ACT_BW-1:0] act_t;
    typedef logic [IDX_BW-1:0] idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_e;
endpackage

// File: rtl/sparse_act_encoder_nz_pick.sv
// Combinational pick of the lowest nz set mask bits into ascending slots,
// with the occupied-slot count and the mask left after those bits are taken.
module nz_pick
    import sparse_pkg::*;
#(
    parameter int bw    = ACT_BW,
    parameter int depth = DEPTH,
    parameter int nz    = NZ,
    localparam int idx_bw = $clog2(depth),
    localparam int cnt_bw = $clog2(nz + 1)
) (
    input  logic [depth-1:0]             mask,
    input  logic [depth-1:0][bw-1:0]     vec,
    output logic [nz-1:0][bw-1:0]        act,
    output logic [nz-1:0][idx_bw-1:0]    index,
    output logic [cnt_bw-1:0]            count,
    output logic [depth-1:0]             mask_clr
);

    int rank;

    // rank is the number of set bits below element i, i.e. the slot it lands in
    always_comb begin
        act      = '0;
        index    = '0;
        mask_clr = mask;
        rank     = 0;
        for (int i = 0; i < depth; i++) begin
            if (mask[i]) begin
                for (int s = 0; s < nz; s++) begin
                    if (rank == s) begin
                        act[s]   = vec[i];
                        index[s] = idx_bw'(i);
                    end
                end
                if (rank < nz) begin
                    mask_clr[i] = 1'b0;
                end
                rank = rank + 1;
            end
        end
        count = (rank < nz) ? cnt_bw'(rank) : cnt_bw'(nz);
    end

endmodule

// File: rtl/sparse_act_encoder.sv
// Dense-to-sparse activation encoder: emits nonzeros as (value, index) packets.
// Define SPARSE_ACT_ENCODER_STATS_EN to add the nnz_total/vec_total counters.
module sparse_act_encoder
    import sparse_pkg::*;
#(
    parameter int bw    = ACT_BW,
    parameter int depth = DEPTH,
    parameter int nz    = NZ,
    localparam int idx_bw = $clog2(depth),
    localparam int cnt_bw = $clog2(nz + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [depth-1:0][bw-1:0]      in_act,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [nz-1:0][bw-1:0]         out_act,
    output logic [nz-1:0][idx_bw-1:0]     out_index,
    output logic [cnt_bw-1:0]             out_count,
    output logic                          out_last
`ifdef SPARSE_ACT_ENCODER_STATS_EN
    ,
    output logic [31:0]                   nnz_total,
    output logic [31:0]                   vec_total
`endif
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_EMIT = EMIT;

    logic [0:0]                   state;
    logic [depth-1:0][bw-1:0]     vec_q;
    logic [depth-1:0]             mask_q;

    logic [nz-1:0][bw-1:0]        pick_act;
    logic [nz-1:0][idx_bw-1:0]    pick_index;
    logic [cnt_bw-1:0]            pick_count;
    logic [depth-1:0]             mask_clr;
    logic                         emit;
    logic                         pick_last;

    nz_pick #(
        .bw    (bw),
        .depth (depth),
        .nz    (nz)
    ) u_pick (
        .mask     (mask_q),
        .vec      (vec_q),
        .act      (pick_act),
        .index    (pick_index),
        .count    (pick_count),
        .mask_clr (mask_clr)
    );

    // Nothing left after this pick means popcount(mask_q) <= nz
    assign pick_last = (mask_clr == '0);
    assign emit      = (state == ST_EMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            vec_q  <= '0;
            mask_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        vec_q <= in_act;
                        for (int i = 0; i < depth; i++) begin
                            mask_q[i] <= (in_act[i] != '0);
                        end
                        state <= ST_EMIT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        mask_q <= mask_clr;
                        if (pick_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are forced to zero outside EMIT so the idle bus is quiet
    assign in_ready  = !emit;
    assign out_valid = emit;
    assign out_act   = emit ? pick_act   : '0;
    assign out_index = emit ? pick_index : '0;
    assign out_count = emit ? pick_count : '0;
    assign out_last  = emit & pick_last;

`ifdef SPARSE_ACT_ENCODER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nnz_total <= '0;
            vec_total <= '0;
        end else begin
            if (in_valid && in_ready) begin
                vec_total <= vec_total + 32'd1;
            end
            if (out_valid && out_ready) begin
                nnz_total <= nnz_total + 32'(out_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sparse_act_encoder.sv
// Self-checking bench for sparse_act_encoder: directed table plus randomized vectors.
module tb_sparse_act_encoder;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0][3:0]      in_act;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0][3:0]      out_act;
    logic [1:0][1:0]      out_index;
    logic [1:0]           out_count;
    logic                 out_last;
`ifdef SPARSE_ACT_ENCODER_STATS_EN
    logic [31:0]          nnz_total;
    logic [31:0]          vec_total;
    int                   acc_vecs = 0;
`endif

    sparse_act_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_index (out_index),
        .out_count (out_count),
        .out_last  (out_last)
`ifdef SPARSE_ACT_ENCODER_STATS_EN
        ,
        .nnz_total (nnz_total),
        .vec_total (vec_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            last;
        logic [1:0]      cnt;
        logic [1:0][1:0] idx;
        logic [1:0][3:0] act;
    } pkt_t;

    typedef struct {
        logic [3:0][3:0] act;
        int              npk;
        pkt_t            pk0;
        pkt_t            pk1;
    } rec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    pkt_t exp_q[$];

    function automatic pkt_t mk(logic l, logic [1:0] c, logic [3:0] v0, logic [1:0] i0,
                                logic [3:0] v1, logic [1:0] i1);
        pkt_t p;
        p.last   = l;
        p.cnt    = c;
        p.act[0] = v0;
        p.idx[0] = i0;
        p.act[1] = v1;
        p.idx[1] = i1;
        return p;
    endfunction

    function automatic pkt_t cur_pkt();
        pkt_t p;
        p.last = out_last;
        p.cnt  = out_count;
        p.idx  = out_index;
        p.act  = out_act;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Reference: list the nonzeros in index order, then cut the list into chunks of two
    function automatic void model(input logic [3:0][3:0] a);
        int vals[$];
        int idxs[$];
        int n;
        int npk;
        for (int i = 0; i < 4; i++) begin
            if (a[i] != 4'd0) begin
                vals.push_back(int'(a[i]));
                idxs.push_back(i);
            end
        end
        n   = vals.size();
        npk = (n == 0) ? 1 : (n + 1) / 2;
        for (int p = 0; p < npk; p++) begin
            pkt_t k;
            int   rem;
            k    = '0;
            rem  = n - 2 * p;
            k.cnt  = 2'((rem > 2) ? 2 : rem);
            k.last = (p == npk - 1);
            for (int s = 0; s < int'(k.cnt); s++) begin
                k.act[s] = 4'(vals[2 * p + s]);
                k.idx[s] = 2'(idxs[2 * p + s]);
            end
            exp_q.push_back(k);
        end
    endfunction

    // Sends one vector and consumes every packet queued in exp_q
    task automatic run_vec(input logic [3:0][3:0] a, input int stall_first,
                           input int stall_rand, input string tag);
        int pn;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_act   = a;
        @(negedge clk);
`ifdef SPARSE_ACT_ENCODER_STATS_EN
        acc_vecs++;
`endif
        pn = 0;
        while (exp_q.size() > 0) begin
            pkt_t e;
            int   st;
            e  = exp_q.pop_front();
            st = (pn == 0) ? stall_first : 0;
            if (stall_rand > 0) st = st + $urandom_range(0, stall_rand);
            for (int k = 0; k < st; k++) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_act    = 16'($urandom);
                check($sformatf("%s pkt%0d stall valid", tag, pn), 32'(out_valid), 32'd1);
                check($sformatf("%s pkt%0d stall hold", tag, pn), 32'(cur_pkt()), 32'(e));
                check($sformatf("%s pkt%0d stall in_ready", tag, pn), 32'(in_ready), 32'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_act    = 16'($urandom);
            check($sformatf("%s pkt%0d valid", tag, pn), 32'(out_valid), 32'd1);
            check($sformatf("%s pkt%0d data", tag, pn), 32'(cur_pkt()), 32'(e));
            check($sformatf("%s pkt%0d in_ready", tag, pn), 32'(in_ready), 32'd0);
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            pn++;
        end
        check({tag, " idle after"}, 32'(out_valid), 32'd0);
    endtask

    rec_t tbl[4];

    initial begin
        logic [3:0][3:0] dense;
        logic [3:0][3:0] sparse;

        tbl[0] = '{act: {4'd5, 4'd0, 4'd7, 4'd0}, npk: 1,
                   pk0: mk(1'b1, 2'd2, 4'd7, 2'd1, 4'd5, 2'd3), pk1: '0};
        tbl[1] = '{act: {4'd4, 4'd3, 4'd2, 4'd1}, npk: 2,
                   pk0: mk(1'b0, 2'd2, 4'd1, 2'd0, 4'd2, 2'd1),
                   pk1: mk(1'b1, 2'd2, 4'd3, 2'd2, 4'd4, 2'd3)};
        tbl[2] = '{act: 16'h0000, npk: 1,
                   pk0: mk(1'b1, 2'd0, 4'd0, 2'd0, 4'd0, 2'd0), pk1: '0};
        tbl[3] = '{act: {4'd0, 4'd9, 4'd0, 4'd0}, npk: 1,
                   pk0: mk(1'b1, 2'd1, 4'd9, 2'd2, 4'd0, 2'd0), pk1: '0};
        dense  = {4'd4, 4'd3, 4'd2, 4'd1};
        sparse = {4'd5, 4'd0, 4'd7, 4'd0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_act    = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset outputs", 32'(cur_pkt()), 32'd0);
        reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            exp_q.push_back(tbl[t].pk0);
            if (tbl[t].npk > 1) exp_q.push_back(tbl[t].pk1);
            run_vec(tbl[t].act, 0, 0, $sformatf("table%0d", t));
        end

        // Backpressure on the dense vector's first packet
        exp_q.push_back(tbl[1].pk0);
        exp_q.push_back(tbl[1].pk1);
        run_vec(dense, 3, 0, "backpressure");

        // Reset between packet 1 and packet 2 of the dense vector
        @(negedge clk);
        in_valid = 1'b1;
        in_act   = dense;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst pkt1", 32'(cur_pkt()), 32'(tbl[1].pk0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("midrst pkt2 shown", 32'(cur_pkt()), 32'(tbl[1].pk1));
        reset = 1'b1;
        #1;
        check("midrst async valid", 32'(out_valid), 32'd0);
        check("midrst async outputs", 32'(cur_pkt()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
`ifdef SPARSE_ACT_ENCODER_STATS_EN
        acc_vecs = 0;
`endif
        @(negedge clk);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst no stale", 32'(out_valid), 32'd0);
        model(sparse);
        run_vec(sparse, 0, 0, "after reset");

        for (int r = 0; r < 60; r++) begin
            logic [3:0][3:0] a;
            for (int i = 0; i < 4; i++) begin
                a[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
            model(a);
            run_vec(a, 0, 2, $sformatf("rand%0d", r));
        end

`ifdef SPARSE_ACT_ENCODER_STATS_EN
        check("vec_total", vec_total, 32'(acc_vecs));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
